// File: rtl/vram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vram_arb_pkg                                                 |
// | Description : Shared types and default sizes for the text VRAM arbiter.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package vram_arb_pkg;

  // Default sizes: 80x30 characters packed 4 per 32-bit word -> 600 words.
  localparam int unsigned c_addr_w_dflt       = 10;
  localparam int unsigned c_data_w_dflt       = 32;
  localparam int unsigned c_starve_limit_dflt = 16;

  // Port arbitration state: free for a grant, or CPU read data returning.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CPU_RSP = 1'b1
  } arb_state_e;

  // Counter width able to hold 0..limit inclusive.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return $clog2(limit + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_starve_mon.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vram_starve_mon                                              |
// | Description : Saturating count of consecutive ungranted CPU-pending        |
// |               cycles, with a sticky flag once the limit is reached.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vram_starve_mon
  import vram_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = c_starve_limit_dflt
) (
  input  logic CLK,
  input  logic RESET,
  input  logic pending,
  input  logic granted,
  output logic starve_err
);

  localparam int unsigned            c_cnt_w = cnt_width(STARVE_LIMIT);
  localparam logic [c_cnt_w-1:0]     c_limit = c_cnt_w'(STARVE_LIMIT);
  localparam logic [c_cnt_w-1:0]     c_one   = c_cnt_w'(1);

  logic [c_cnt_w-1:0] wait_cnt_q, wait_cnt_d;
  logic               starve_err_q, starve_err_d;

  // Next count: clear on grant or no request, else count up and hold at the limit.
  always_comb begin
    wait_cnt_d   = wait_cnt_q;
    if (!pending || granted) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != c_limit) begin
      wait_cnt_d = wait_cnt_q + c_one;
    end
    // Flag rises on the same edge the count reaches the limit, then sticks.
    starve_err_d = starve_err_q | (wait_cnt_d == c_limit);
  end

  // Counter and sticky flag registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wait_cnt_q   <= '0;
      starve_err_q <= 1'b0;
    end else begin
      wait_cnt_q   <= wait_cnt_d;
      starve_err_q <= starve_err_d;
    end
  end

  assign starve_err = starve_err_q;

endmodule
`default_nettype wire

// File: rtl/vram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vram_port_arbiter                                            |
// | Description : Shares a single-port text VRAM between the VGA fetch path    |
// |               (absolute priority) and an Avalon-MM CPU slave.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = c_addr_w_dflt,
  parameter int unsigned DATA_W       = c_data_w_dflt,
  parameter int unsigned STARVE_LIMIT = c_starve_limit_dflt
) (
  input  logic                  CLK,
  input  logic                  RESET,
  // VGA character fetch
  input  logic                  vga_req,
  input  logic [ADDR_W-1:0]     vga_addr,
  output logic [DATA_W-1:0]     vga_rdata,
  output logic                  vga_valid,
  // Avalon-MM slave
  input  logic                  avl_read,
  input  logic                  avl_write,
  input  logic [ADDR_W-1:0]     avl_address,
  input  logic [DATA_W-1:0]     avl_writedata,
  input  logic [DATA_W/8-1:0]   avl_byteenable,
  output logic [DATA_W-1:0]     avl_readdata,
  output logic                  avl_waitrequest,
  // VRAM port
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_we,
  output logic [DATA_W/8-1:0]   ram_be,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  // Status
  output logic                  starve_err
);

  arb_state_e state_q, state_d;
  logic       vga_valid_q, vga_valid_d;

  logic       w_cpu_wr_grant;
  logic       w_cpu_rd_grant;
  logic       w_cpu_pending;
  logic       w_cpu_granted;

  // Grant decision: VGA first, then a CPU write, then a CPU read (IDLE only).
  always_comb begin
    w_cpu_wr_grant = !vga_req && (state_q == IDLE) && avl_write;
    w_cpu_rd_grant = !vga_req && (state_q == IDLE) && !avl_write && avl_read;
    w_cpu_pending  = avl_read | avl_write;
    // The response cycle counts as service so the watchdog does not tick on it.
    w_cpu_granted  = w_cpu_wr_grant | w_cpu_rd_grant | (state_q == CPU_RSP);
  end

  // State and VGA response pipeline registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      vga_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vga_valid_q <= vga_valid_d;
    end
  end

  // Next state: an accepted read spends exactly one cycle returning data.
  always_comb begin
    state_d     = state_q;
    vga_valid_d = vga_req;
    case (state_q)
      IDLE:    if (w_cpu_rd_grant) state_d = CPU_RSP;
      CPU_RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Port and handshake outputs; the RAM sees VGA address whenever it requests.
  always_comb begin
    ram_addr        = vga_req ? vga_addr : avl_address;
    ram_we          = w_cpu_wr_grant;
    ram_be          = avl_byteenable;
    ram_wdata       = avl_writedata;
    avl_waitrequest = !(w_cpu_wr_grant || (state_q == CPU_RSP));
    avl_readdata    = ram_rdata;
    vga_rdata       = ram_rdata;
    vga_valid       = vga_valid_q;
  end

  vram_starve_mon #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_mon (
    .CLK        (CLK),
    .RESET      (RESET),
    .pending    (w_cpu_pending),
    .granted    (w_cpu_granted),
    .starve_err (starve_err)
  );

endmodule
`default_nettype wire
